// File: rtl/trap_ctrl.sv
// Trap/mret sequencer: flush, drain the pipeline, commit CSR strobes, then redirect fetch.
// Optional interrupt entry is enabled by defining TRAP_CTRL_INTR_EN.
module trap_ctrl #(
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic        mret_req,
    input  logic [31:0] mtvec_rd,
    input  logic [31:0] mepc_rd,
    input  logic        mstatus_mie,
    input  logic        pipe_empty,
    input  logic        redirect_ready,
    input  logic        irq_timer,
    input  logic        irq_ext,
    output logic        stall,
    output logic        flush,
    output logic        trap_we,
    output logic        mret_we,
    output logic [31:0] mepc_out,
    output logic [3:0]  mcause_out,
    output logic [31:0] mtval_out,
    output logic        intr_out,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

    localparam logic       KIND_TRAP = 1'b0;
    localparam logic       KIND_MRET = 1'b1;
    localparam logic [3:0] DRAIN_LIM = 4'(DRAIN_MAX);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] rpc_q, rpc_d;
    logic        kind_q, kind_d;
    logic        intr_q, intr_d;
    logic        take_irq;
    logic [3:0]  irq_cause;
    logic        unused_bits;

    assign unused_bits = ^mtvec_rd[1:0];

`ifdef TRAP_CTRL_INTR_EN
    // External interrupt has priority over the timer.
    assign take_irq  = mstatus_mie && (irq_ext || irq_timer);
    assign irq_cause = irq_ext ? 4'd11 : 4'd7;
    assign intr_out  = busy && intr_q;
`else
    logic unused_irq;
    assign take_irq   = 1'b0;
    assign irq_cause  = 4'd0;
    assign intr_out   = 1'b0;
    assign unused_irq = ^{irq_timer, irq_ext, mstatus_mie, intr_q};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            rpc_q   <= '0;
            kind_q  <= KIND_TRAP;
            intr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
            rpc_q   <= rpc_d;
            kind_q  <= kind_d;
            intr_q  <= intr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        tval_d  = tval_q;
        rpc_d   = rpc_q;
        kind_d  = kind_q;
        intr_d  = intr_q;
        flush   = 1'b0;
        trap_we = 1'b0;
        mret_we = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (exc_valid) begin
                    cause_d = exc_cause;
                    pc_d    = exc_pc;
                    tval_d  = exc_tval;
                    kind_d  = KIND_TRAP;
                    intr_d  = 1'b0;
                    flush   = !reset;
                    state_d = DRAIN;
                end else if (mret_req) begin
                    cause_d = '0;
                    pc_d    = '0;
                    tval_d  = '0;
                    kind_d  = KIND_MRET;
                    intr_d  = 1'b0;
                    flush   = !reset;
                    state_d = DRAIN;
                end else if (take_irq) begin
                    cause_d = irq_cause;
                    pc_d    = exc_pc;
                    tval_d  = '0;
                    kind_d  = KIND_TRAP;
                    intr_d  = 1'b1;
                    flush   = !reset;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // DRAIN lasts at most DRAIN_MAX cycles even if the pipe never empties.
                cnt_d = cnt_q + 4'd1;
                if (pipe_empty || cnt_d == DRAIN_LIM) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                trap_we = (kind_q == KIND_TRAP);
                mret_we = (kind_q == KIND_MRET);
                rpc_d   = (kind_q == KIND_MRET) ? mepc_rd : {mtvec_rd[31:2], 2'b00};
                state_d = REDIRECT;
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign stall          = busy;
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = redirect_valid ? rpc_q : 32'd0;
    assign mepc_out       = busy ? pc_q : 32'd0;
    assign mcause_out     = busy ? cause_q : 4'd0;
    assign mtval_out      = (busy && cause_q == 4'd2) ? tval_q : 32'd0;
endmodule
